// File: rtl/alu_instr_enc_if.sv
// alu_instr_enc_if: request and instruction-stream bundle for alu_instr_enc.
interface alu_instr_enc_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_imm_mode;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [11:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  modport master (
    output req_valid, req_op, req_imm_mode, req_rd, req_rs1, req_rs2, req_imm, instr_ready,
    input  req_ready, instr_valid, instr
  );
  modport slave (
    input  req_valid, req_op, req_imm_mode, req_rd, req_rs1, req_rs2, req_imm, instr_ready,
    output req_ready, instr_valid, instr
  );
endinterface

// File: rtl/alu_instr_enc.sv
// alu_instr_enc: ALU request -> RV32I OP/OP-IMM word encoder feeding a small FIFO.
// Optional ALU_ENC_NEG_IMM_EN makes I-type sub legal, encoded as addi with negated immediate.
module alu_instr_enc #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_instr_enc_if.slave         bus,
  output logic                   err_o,
  output logic [CNT_W-1:0]       err_cnt_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_sub, bad_op, neg_ok, illegal, accept, push, pop;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [11:0]      imm;
  logic [31:0]      word;
  assign is_sub = bus.req_op == 3'b001;
  assign bad_op = bus.req_op == 3'b100 || bus.req_op[2:1] == 2'b11;
`ifdef ALU_ENC_NEG_IMM_EN
  // -2048 has no positive 12-bit counterpart
  assign neg_ok = bus.req_imm != 12'h800;
`else
  assign neg_ok = 1'b0;
`endif
  assign illegal = bad_op || (bus.req_imm_mode && is_sub && !neg_ok);
  assign f3 = bus.req_op == 3'b101 ? 3'b010 :
              bus.req_op == 3'b011 ? 3'b110 :
              bus.req_op == 3'b010 ? 3'b111 : 3'b000;
  assign f7   = is_sub ? 7'b0100000 : 7'b0000000;
  assign imm  = is_sub ? -bus.req_imm : bus.req_imm;
  assign word = bus.req_imm_mode ? {imm, bus.req_rs1, f3, bus.req_rd, 7'b0010011}
                                 : {f7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, 7'b0110011};
  assign bus.req_ready   = level_q != (AW+1)'(DEPTH);
  assign bus.instr_valid = level_q != '0;
  assign bus.instr       = bus.instr_valid ? mem_q[rd_ptr_q] : 32'h0000_0013;
  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && !illegal;
  assign pop    = bus.instr_valid && bus.instr_ready;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    err_d    = accept && illegal;
    cnt_d    = (err_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
  // storage needs no reset: the head is masked to a NOP while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
  assign level_o   = level_q;
endmodule

// File: doc/alu_instr_enc.md
# alu_instr_enc

Encoder counterpart of the ALU control decoder: accepts abstract ALU operation requests (3-bit ALU control code, register indices, optional 12-bit immediate) and emits the matching RV32I OP / OP-IMM instruction words through a small FIFO. It sits in the debug path ahead of the single-cycle core's instruction memory loader or feeder. Encoded words therefore decode back to the same ALU control code in the core. Illegal requests are consumed, dropped and flagged.

## Interface
Parameters:
- DEPTH, 4, output FIFO entries; power of two, ≥ 2
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  3  ALU control code: 000 add, 001 sub, 101 slt, 011 or, 010 and
- req_imm_mode  input  1  1 = I-type (OP-IMM), 0 = R-type (OP)
- req_rd / req_rs1 / req_rs2  input  5 each  register indices; rs2 ignored in I-type
- req_imm  input  12  two's-complement immediate; ignored in R-type
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  downstream accepts head
- instr  output  32  encoded instruction at FIFO head
- err  output  1  one-cycle pulse: illegal request dropped
- err_cnt  output  CNT_W  saturating count of dropped requests
- level  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Request accepted on a clk edge with req_valid && req_ready. req_ready = (level != DEPTH); a same-cycle pop does not free space for a push.
- Encoding: opcode 0110011 (R) or 0010011 (I).
  - funct3: add/sub 000, slt 010, or 110, and 111.
  - R-type funct7: 0100000 for sub, else 0000000.
  - I-type word: imm[11:0] | rs1 | funct3 | rd | opcode.
  - R-type word: funct7 | rs2 | rs1 | funct3 | rd | opcode.
- Illegal request: req_op ∈ {100, 110, 111}, or sub with req_imm_mode = 1 (see Configuration).
  - Request is accepted (req_ready handshake completes) but nothing is written to the FIFO.
  - err pulses high for the following cycle.
  - err_cnt increments and holds at all-ones.
- FIFO: circular buffer with read/write pointers; pointers wrap modulo DEPTH; level tracks occupancy.
  - Pop on instr_valid && instr_ready.
  - Simultaneous legal push and pop with 0 < level < DEPTH keeps level unchanged.
- instr_valid = (level != 0). instr holds the head entry and is stable while instr_valid && !instr_ready.
- Reset (asynchronous, any time, including mid-transfer) clears all in-flight words and gives:
  - pointers 0, level 0, instr_valid 0, req_ready 1
  - err 0, err_cnt 0, instr 32'h0000_0013 (addi x0,x0,0)

## Timing
- Accept → instr_valid: 1 cycle when the FIFO is empty; there is no combinational input-to-output path.
- Accept of an illegal request → err high in the next cycle, for exactly one cycle; err_cnt updates on the same edge.
- Throughput: one request per cycle while not full; one instruction per cycle while not empty.
- Full: req_ready low until a pop has completed (registered level decrements), i.e. the cycle after the pop.
- Empty with simultaneous push: no bypass; the word becomes visible in the next cycle.

## Configuration
- ALU_ENC_NEG_IMM_EN
  - Defined: sub with req_imm_mode = 1 is legal and is encoded as addi with immediate −req_imm. req_imm = 12'h800 remains illegal, because its negation overflows 12 bits.
  - Undefined: every I-type sub is illegal (dropped, err pulse).

## Test plan
- Reset, then request R-type add rd=1, rs1=2, rs2=3 → instr 32'h0031_00B3 one cycle after accept; level 1.
- R-type sub rd=5, rs1=6, rs2=7 → 32'h4073_02B3. I-type and rd=8, rs1=9, imm=12'h0FF → 32'h0FF4_F413. I-type slt rd=1, rs1=1, imm=12'hFFF → 32'hFFF0_A093.
- Push 4 requests with instr_ready=0 → req_ready 0 once level=4. Raise instr_ready for one cycle → one pop; req_ready 1 the cycle after; output order preserved.
- Request req_op=100 → consumed, err pulses once, err_cnt=1, level unchanged. Drive 300 illegal requests → err_cnt holds at 8'hFF.
- I-type sub rd=1, rs1=1, imm=5:
  - With ALU_ENC_NEG_IMM_EN defined → 32'hFFB0_8093.
  - Without it → err pulse, no FIFO write.
  - With it defined and imm=12'h800 → err pulse, no FIFO write.
- With level=3, assert rst_n=0 asynchronously mid-cycle → instr_valid 0, level 0 and instr 32'h0000_0013 immediately; after release, a new request encodes correctly.
